stack_engine_param: RTL and testbench

//  Parametrised hardware stack for the CPU emulator: pointer, level counter and

---
 rtl/stack_engine_param.sv | 127 ++++++++++++
 tb/tb_stack_engine_param.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/stack_engine_param.sv
// rtl/stack_engine_param.sv - parametrised descending hardware stack
// Supports push/pop/exchange, level flags, sticky errors and flush.
module stack_engine_param #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 8,
  parameter int AF_LEVEL = 240
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PUSH,
  input  logic              POP,
  input  logic [DATA_W-1:0] PUSH_DATA,
  input  logic              FLUSH,
  input  logic              CLR_ERR,
  output logic [DATA_W-1:0] POP_DATA,
  output logic              POP_VALID,
  output logic [ADDR_W-1:0] SP,
  output logic [ADDR_W:0]   LEVEL,
  output logic              EMPTY,
  output logic              FULL,
  output logic              ALMOST_FULL,
  output logic              OVF,
  output logic              UNF
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_LVL   = AF_LEVEL[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              pop_valid_q, pop_valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W-1:0] sp_p1;
  logic              empty, full;
  logic              ovf_set, unf_set;

  assign sp_p1 = sp_q + 1'b1;
  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LVL);

  always_comb begin
    sp_d        = sp_q;
    level_d     = level_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = sp_q;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;

    if (FLUSH) begin
      sp_d    = '1;
      level_d = '0;
    end else if (PUSH && POP && !empty) begin
      // Exchange replaces the top entry in place; legal even when full.
      pop_data_d  = mem[sp_p1];
      pop_valid_d = 1'b1;
      mem_we      = 1'b1;
      mem_waddr   = sp_p1;
    end else if (PUSH) begin
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        mem_we    = 1'b1;
        mem_waddr = sp_q;
        sp_d      = sp_q - 1'b1;
        level_d   = level_q + 1'b1;
      end
    end else if (POP) begin
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        pop_data_d  = mem[sp_p1];
        pop_valid_d = 1'b1;
        sp_d        = sp_p1;
        level_d     = level_q - 1'b1;
      end
    end

    // An error event in the same cycle as CLR_ERR keeps the flag set.
    ovf_d = ovf_set | (ovf_q & ~CLR_ERR);
    unf_d = unf_set | (unf_q & ~CLR_ERR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sp_q        <= '1;
      level_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      level_q     <= level_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we && !RST) begin
      mem[mem_waddr] <= PUSH_DATA;
    end
  end

  assign POP_DATA    = pop_data_q;
  assign POP_VALID   = pop_valid_q;
  assign SP          = sp_q;
  assign LEVEL       = level_q;
  assign EMPTY       = empty;
  assign FULL        = full;
  assign ALMOST_FULL = (level_q >= AF_LVL);
  assign OVF         = ovf_q;
  assign UNF         = unf_q;

endmodule

// File: tb/tb_stack_engine_param.sv
// tb/tb_stack_engine_param.sv - scoreboard bench for stack_engine_param
// Stimulus queues expected pop data; a negedge monitor pops and compares.
module tb_stack_engine_param;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PUSH = 1'b0;
  logic       POP = 1'b0;
  logic [3:0] PUSH_DATA = '0;
  logic       FLUSH = 1'b0;
  logic       CLR_ERR = 1'b0;
  logic [3:0] POP_DATA;
  logic       POP_VALID;
  logic [1:0] SP;
  logic [2:0] LEVEL;
  logic       EMPTY, FULL, ALMOST_FULL, OVF, UNF;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  stack_engine_param #(.DATA_W(4), .ADDR_W(2), .AF_LEVEL(3)) dut (
    .CLK(CLK), .RST(RST), .PUSH(PUSH), .POP(POP), .PUSH_DATA(PUSH_DATA),
    .FLUSH(FLUSH), .CLR_ERR(CLR_ERR), .POP_DATA(POP_DATA), .POP_VALID(POP_VALID),
    .SP(SP), .LEVEL(LEVEL), .EMPTY(EMPTY), .FULL(FULL), .ALMOST_FULL(ALMOST_FULL),
    .OVF(OVF), .UNF(UNF)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (POP_VALID) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got=%h expected no pop", POP_DATA);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (POP_DATA !== e) begin
          errors++;
          $display("FAIL pop_data got=%h expected=%h", POP_DATA, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock with the given inputs; state is checked 1 time unit after the edge.
  task automatic cyc(input logic push, input logic pop, input logic [3:0] d,
                     input logic flush, input logic clr,
                     input logic exp_v, input logic [3:0] exp_d);
    PUSH = push; POP = pop; PUSH_DATA = d; FLUSH = flush; CLR_ERR = clr;
    if (exp_v) exp_q.push_back(exp_d);
    @(posedge CLK); #1;
    PUSH = 1'b0; POP = 1'b0; FLUSH = 1'b0; CLR_ERR = 1'b0;
    chk("pop_valid", POP_VALID, exp_v);
  endtask

  task automatic push1(input logic [3:0] d);
    cyc(1, 0, d, 0, 0, 0, 4'h0);
  endtask

  task automatic pop1(input logic [3:0] e);
    cyc(0, 1, 4'h0, 0, 0, 1, e);
  endtask

  initial begin
    // 1 reset
    @(posedge CLK); @(posedge CLK); #1;
    chk("rst_sp", SP, 3);
    chk("rst_level", LEVEL, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_af", ALMOST_FULL, 0);
    chk("rst_pop_valid", POP_VALID, 0);
    chk("rst_pop_data", POP_DATA, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_unf", UNF, 0);
    RST = 1'b0;

    // 2 fill and drain
    push1(4'hA); chk("t2_sp_a", SP, 2); chk("t2_lvl_a", LEVEL, 1); chk("t2_af_a", ALMOST_FULL, 0);
    push1(4'hB); chk("t2_sp_b", SP, 1); chk("t2_af_b", ALMOST_FULL, 0);
    push1(4'hC); chk("t2_sp_c", SP, 0); chk("t2_af_c", ALMOST_FULL, 1); chk("t2_full_c", FULL, 0);
    push1(4'hD); chk("t2_sp_d", SP, 3); chk("t2_lvl_d", LEVEL, 4); chk("t2_full_d", FULL, 1);
    pop1(4'hD); chk("t2_sp_pop1", SP, 0);
    pop1(4'hC);
    pop1(4'hB); chk("t2_af_pop3", ALMOST_FULL, 0);
    pop1(4'hA);
    chk("t2_empty", EMPTY, 1); chk("t2_sp_end", SP, 3); chk("t2_lvl_end", LEVEL, 0);

    // 3 errors, exchange while full
    push1(4'h1); push1(4'h2); push1(4'h3); push1(4'h4);
    push1(4'h5); chk("t3_ovf_lvl", LEVEL, 4); chk("t3_ovf", OVF, 1); chk("t3_ovf_sp", SP, 3);
    cyc(0, 0, 4'h0, 0, 1, 0, 4'h0); chk("t3_ovf_clr", OVF, 0);
    cyc(1, 1, 4'h6, 0, 0, 1, 4'h4); chk("t3_xchg_full_ovf", OVF, 0); chk("t3_xchg_lvl", LEVEL, 4);
    pop1(4'h6); pop1(4'h3); pop1(4'h2); pop1(4'h1);
    cyc(0, 1, 4'h0, 0, 0, 0, 4'h0);
    chk("t3_unf", UNF, 1); chk("t3_pop_held", POP_DATA, 4'h1); chk("t3_unf_lvl", LEVEL, 0);
    push1(4'h5); push1(4'h5); push1(4'h5); push1(4'h5); push1(4'h5);
    chk("t3_both_ovf", OVF, 1);
    cyc(0, 0, 4'h0, 0, 1, 0, 4'h0); chk("t3_clr_ovf", OVF, 0); chk("t3_clr_unf", UNF, 0);
    cyc(0, 0, 4'h0, 1, 0, 0, 4'h0);
    cyc(0, 1, 4'h0, 0, 1, 0, 4'h0); chk("t3_clr_vs_unf", UNF, 1);
    cyc(0, 0, 4'h0, 0, 1, 0, 4'h0); chk("t3_unf_cleared", UNF, 0);

    // 4 exchange
    push1(4'h1); push1(4'h2);
    cyc(1, 1, 4'h7, 0, 0, 1, 4'h2); chk("t4_lvl", LEVEL, 2); chk("t4_sp", SP, 1);
    pop1(4'h7); pop1(4'h1);

    // 5 push&pop while empty
    cyc(1, 1, 4'h9, 0, 0, 0, 4'h0); chk("t5_lvl", LEVEL, 1); chk("t5_unf", UNF, 0);
    pop1(4'h9);

    // 6 flush with push, then reset mid-pop
    push1(4'h3); push1(4'h4); push1(4'h5);
    cyc(1, 0, 4'h8, 1, 0, 0, 4'h0);
    chk("t6_lvl", LEVEL, 0); chk("t6_sp", SP, 3); chk("t6_empty", EMPTY, 1);
    push1(4'hE); push1(4'hF);
    POP = 1'b1;
    #2 RST = 1'b1;
    @(posedge CLK); #1;
    chk("t6_rst_pop_valid", POP_VALID, 0); chk("t6_rst_lvl", LEVEL, 0); chk("t6_rst_sp", SP, 3);
    POP = 1'b0;
    RST = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
